// File: rtl/status_register_stack_if.sv
// Bus bundle for status_register_stack: flag write inputs, push/pop controls and status outputs.
interface status_register_stack_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] status_in;
    logic [WIDTH-1:0] status_wr_mask;
    logic             status_push;
    logic             status_pop;
    logic [WIDTH-1:0] status_out;
    logic [DW-1:0]    status_depth;
    logic             status_full;
    logic             status_empty;
    logic             status_err;

    modport master (
        output status_in, status_wr_mask, status_push, status_pop,
        input  status_out, status_depth, status_full, status_empty, status_err
    );

    modport slave (
        input  status_in, status_wr_mask, status_push, status_pop,
        output status_out, status_depth, status_full, status_empty, status_err
    );
endinterface

// File: rtl/status_register_stack.sv
// Masked-write status register with a LIFO save/restore stack.
// Optional STATUS_ERR_STICKY_EN: overflow/underflow error holds until reset instead of pulsing.
module status_register_stack #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input logic                   clock,
    input logic                   status_reset,
    status_register_stack_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_out;
    logic [DW-1:0]    r_depth;
    logic             r_err;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_written;
    logic [WIDTH-1:0] w_out_next;
    logic [DW-1:0]    w_depth_next;
    logic             w_stack_we;
    logic [IW-1:0]    w_stack_idx;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_push_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_event;

    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_top_idx  = IW'(r_depth - 1'b1);
    assign w_push_idx = IW'(r_depth);
    assign w_written  = (r_out & ~bus.status_wr_mask) | (bus.status_in & bus.status_wr_mask);

    always_comb begin
        w_out_next   = w_written;
        w_depth_next = r_depth;
        w_stack_we   = 1'b0;
        w_stack_idx  = w_push_idx;
        w_event      = 1'b0;
        if (bus.status_pop) begin
            if (w_empty) begin
                w_event = 1'b1;
            end else begin
                // Exchange swaps in place; a plain pop drops the top entry.
                w_out_next = r_stack[w_top_idx];
                if (bus.status_push) begin
                    w_stack_we  = 1'b1;
                    w_stack_idx = w_top_idx;
                end else begin
                    w_depth_next = r_depth - 1'b1;
                end
            end
        end else if (bus.status_push) begin
            if (w_full) begin
                w_event = 1'b1;
            end else begin
                w_stack_we   = 1'b1;
                w_depth_next = r_depth + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (status_reset) begin
            r_out   <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_depth <= w_depth_next;
`ifdef STATUS_ERR_STICKY_EN
            r_err   <= r_err | w_event;
`else
            r_err   <= w_event;
`endif
        end
    end

    // Stack contents are not reset; depth alone decides what is reachable.
    always_ff @(posedge clock) begin
        if (!status_reset && w_stack_we) begin
            r_stack[w_stack_idx] <= r_out;
        end
    end

    assign bus.status_out   = r_out;
    assign bus.status_depth = r_depth;
    assign bus.status_full  = w_full;
    assign bus.status_empty = w_empty;
    assign bus.status_err   = r_err;
endmodule

// File: tb/tb_status_register_stack.sv
// Directed self-checking bench for status_register_stack (WIDTH=2, DEPTH=4), both err builds.
module tb_status_register_stack;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    status_register_stack_if #(.WIDTH(2), .DEPTH(4)) bus ();

    status_register_stack #(.WIDTH(2), .DEPTH(4)) dut (
        .clock        (clk),
        .status_reset (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STATUS_ERR_STICKY_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected empty/full follow from the expected depth.
    task automatic check_state(input string tag, input logic [1:0] out, input int depth,
                               input logic err);
        check_eq({tag, ".out"}, 32'(bus.status_out), 32'(out));
        check_eq({tag, ".depth"}, 32'(bus.status_depth), 32'(depth));
        check_eq({tag, ".empty"}, 32'(bus.status_empty), 32'(depth == 0));
        check_eq({tag, ".full"}, 32'(bus.status_full), 32'(depth == 4));
        check_eq({tag, ".err"}, 32'(bus.status_err), 32'(err));
    endtask

    task automatic step(input logic [1:0] din, input logic [1:0] mask, input logic push,
                        input logic pop, input logic reset);
        bus.status_in      = din;
        bus.status_wr_mask = mask;
        bus.status_push    = push;
        bus.status_pop     = pop;
        rst                = reset;
        @(posedge clk);
        #1;
        bus.status_wr_mask = 2'b00;
        bus.status_push    = 1'b0;
        bus.status_pop     = 1'b0;
        rst                = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.status_in      = 2'b00;
        bus.status_wr_mask = 2'b00;
        bus.status_push    = 1'b0;
        bus.status_pop     = 1'b0;
        rst                = 1'b1;
        @(negedge clk);

        // Reset and masked writes
        step(2'b00, 2'b00, 0, 0, 1); check_state("reset", 2'b00, 0, 0);
        step(2'b11, 2'b01, 0, 0, 0); check_state("wr01", 2'b01, 0, 0);
        step(2'b00, 2'b10, 0, 0, 0); check_state("wr10", 2'b01, 0, 0);
        step(2'b10, 2'b11, 0, 0, 0); check_state("wr11", 2'b10, 0, 0);

        // Push/pop round trip
        step(2'b01, 2'b11, 1, 0, 0); check_state("rt_push", 2'b01, 1, 0);
        step(2'b00, 2'b00, 0, 1, 0); check_state("rt_pop", 2'b10, 0, 0);

        // Fill with 00,01,10,11 then overflow
        step(2'b00, 2'b11, 0, 0, 0); check_state("fill_init", 2'b00, 0, 0);
        step(2'b01, 2'b11, 1, 0, 0); check_state("fill1", 2'b01, 1, 0);
        step(2'b10, 2'b11, 1, 0, 0); check_state("fill2", 2'b10, 2, 0);
        step(2'b11, 2'b11, 1, 0, 0); check_state("fill3", 2'b11, 3, 0);
        step(2'b00, 2'b00, 1, 0, 0); check_state("fill4", 2'b11, 4, 0);
        step(2'b01, 2'b01, 1, 0, 0); check_state("ovf", 2'b11, 4, 1);
        step(2'b00, 2'b00, 0, 0, 0); check_state("ovf_next", 2'b11, 4, Sticky);
        step(2'b00, 2'b00, 0, 1, 0); check_state("drain1", 2'b11, 3, Sticky);
        step(2'b00, 2'b00, 0, 1, 0); check_state("drain2", 2'b10, 2, Sticky);
        step(2'b00, 2'b00, 0, 1, 0); check_state("drain3", 2'b01, 1, Sticky);
        step(2'b00, 2'b00, 0, 1, 0); check_state("drain4", 2'b00, 0, Sticky);

        // Underflow with write applied
        step(2'b00, 2'b00, 0, 0, 1); check_state("rst2", 2'b00, 0, 0);
        step(2'b11, 2'b11, 0, 1, 0); check_state("unf", 2'b11, 0, 1);
        step(2'b00, 2'b00, 0, 0, 0); check_state("unf_next", 2'b11, 0, Sticky);

        // Exchange: top=01, out=10
        step(2'b00, 2'b00, 0, 0, 1); check_state("rst3", 2'b00, 0, 0);
        step(2'b01, 2'b11, 0, 0, 0); check_state("xc_wr", 2'b01, 0, 0);
        step(2'b10, 2'b11, 1, 0, 0); check_state("xc_push", 2'b10, 1, 0);
        step(2'b11, 2'b11, 1, 1, 0); check_state("xchg", 2'b01, 1, 0);
        step(2'b00, 2'b00, 0, 1, 0); check_state("xc_top", 2'b10, 0, 0);
        step(2'b11, 2'b11, 1, 1, 0); check_state("xc_empty", 2'b11, 0, 1);

        // Reset overrides a same-cycle pop
        step(2'b00, 2'b00, 0, 0, 1); check_state("rst4", 2'b00, 0, 0);
        step(2'b01, 2'b11, 1, 0, 0); check_state("mid1", 2'b01, 1, 0);
        step(2'b10, 2'b11, 1, 0, 0); check_state("mid2", 2'b10, 2, 0);
        step(2'b11, 2'b11, 1, 0, 0); check_state("mid3", 2'b11, 3, 0);
        step(2'b00, 2'b00, 0, 1, 1); check_state("mid_rst", 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 1, 0); check_state("post_unf", 2'b00, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
